// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of out-of-order results, with
// mispredict flush. Optional operand forwarding ports are built when
// ROB_FWD_EN is defined.
module reorder_buffer #(
   parameter int unsigned ROB_DEPTH = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        alloc_valid,
   input  logic [4:0]  alloc_rd,
   output logic        alloc_ready,
   output logic [31:0] alloc_tag,
   input  logic        wb_valid,
   input  logic [31:0] wb_tag,
   input  logic [31:0] wb_value,
   input  logic        wb_mispredict,
   input  logic [31:0] wb_target,
   output logic        commit_en,
   output logic [4:0]  commit_rd,
   output logic [31:0] commit_value,
   output logic [31:0] commit_tag,
   output logic        clear,
   output logic [31:0] clear_pc
`ifdef ROB_FWD_EN
   ,
   input  logic [31:0] q1_tag,
   input  logic [31:0] q2_tag,
   output logic        q1_ready,
   output logic        q2_ready,
   output logic [31:0] q1_value,
   output logic [31:0] q2_value
`endif
);

   localparam int unsigned IDX_W = $clog2(ROB_DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;

   logic [ROB_DEPTH-1:0] busy_q, busy_d, done_q, done_d, misp_q, misp_d;
   logic [4:0]           rd_q     [ROB_DEPTH];
   logic [4:0]           rd_d     [ROB_DEPTH];
   logic [31:0]          value_q  [ROB_DEPTH];
   logic [31:0]          value_d  [ROB_DEPTH];
   logic [31:0]          target_q [ROB_DEPTH];
   logic [31:0]          target_d [ROB_DEPTH];
   logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d, wb_idx;
   logic [CNT_W-1:0]     count_q, count_d;

   logic                 commit_en_q, commit_en_d, clear_q, clear_d;
   logic [4:0]           commit_rd_q, commit_rd_d;
   logic [31:0]          commit_value_q, commit_value_d;
   logic [31:0]          commit_tag_q, commit_tag_d;
   logic [31:0]          clear_pc_q, clear_pc_d;
   logic                 do_alloc, do_wb, do_retire, do_flush;

   assign alloc_ready  = (count_q != CNT_W'(ROB_DEPTH));
   assign alloc_tag    = 32'(tail_q);
   assign commit_en    = commit_en_q;
   assign commit_rd    = commit_rd_q;
   assign commit_value = commit_value_q;
   assign commit_tag   = commit_tag_q;
   assign clear        = clear_q;
   assign clear_pc     = clear_pc_q;
   assign wb_idx       = wb_tag[IDX_W-1:0];

   // Next-state: allocate at tail, record writebacks, retire/flush at head
   always_comb begin
      busy_d         = busy_q;
      done_d         = done_q;
      misp_d         = misp_q;
      rd_d           = rd_q;
      value_d        = value_q;
      target_d       = target_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      commit_en_d    = 1'b0;
      commit_rd_d    = commit_rd_q;
      commit_value_d = commit_value_q;
      commit_tag_d   = commit_tag_q;
      clear_d        = 1'b0;
      clear_pc_d     = clear_pc_q;
      do_alloc       = 1'b0;
      do_wb          = 1'b0;
      do_retire      = 1'b0;
      do_flush       = 1'b0;
      if (rdy_in) begin
         do_alloc  = alloc_valid && alloc_ready;
         do_wb     = wb_valid && (wb_tag < 32'(ROB_DEPTH)) && busy_q[wb_idx];
         do_retire = (count_q != '0) && done_q[head_q];
         do_flush  = do_retire && misp_q[head_q];
         if (do_alloc) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            rd_d[tail_q]   = alloc_rd;
            tail_d         = tail_q + IDX_W'(1);
         end
         if (do_wb) begin
            done_d[wb_idx]   = 1'b1;
            value_d[wb_idx]  = wb_value;
            misp_d[wb_idx]   = wb_mispredict;
            target_d[wb_idx] = wb_target;
         end
         if (do_retire) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + IDX_W'(1);
            commit_en_d    = (rd_q[head_q] != 5'd0);
            commit_rd_d    = rd_q[head_q];
            commit_value_d = value_q[head_q];
            commit_tag_d   = 32'(head_q);
         end
         count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_retire);
         // Flush overrides any same-cycle allocation or writeback
         if (do_flush) begin
            busy_d     = '0;
            done_d     = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            clear_d    = 1'b1;
            clear_pc_d = target_q[head_q];
         end
      end
   end

   // Control state and registered outputs, synchronous active-low reset
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         busy_q         <= '0;
         done_q         <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_en_q    <= 1'b0;
         commit_rd_q    <= 5'd0;
         commit_value_q <= 32'd0;
         commit_tag_q   <= 32'd0;
         clear_q        <= 1'b0;
         clear_pc_q     <= 32'd0;
      end else begin
         busy_q         <= busy_d;
         done_q         <= done_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         commit_en_q    <= commit_en_d;
         commit_rd_q    <= commit_rd_d;
         commit_value_q <= commit_value_d;
         commit_tag_q   <= commit_tag_d;
         clear_q        <= clear_d;
         clear_pc_q     <= clear_pc_d;
      end
   end

   // Entry payload storage; meaningful only while busy, so no reset
   always_ff @(posedge clk_in) begin
      misp_q   <= misp_d;
      rd_q     <= rd_d;
      value_q  <= value_d;
      target_q <= target_d;
   end

`ifdef ROB_FWD_EN
   // Operand forwarding lookups against completed, still-live entries
   always_comb begin
      q1_ready = (q1_tag < 32'(ROB_DEPTH)) && busy_q[q1_tag[IDX_W-1:0]]
                 && done_q[q1_tag[IDX_W-1:0]];
      q2_ready = (q2_tag < 32'(ROB_DEPTH)) && busy_q[q2_tag[IDX_W-1:0]]
                 && done_q[q2_tag[IDX_W-1:0]];
      q1_value = q1_ready ? value_q[q1_tag[IDX_W-1:0]] : 32'd0;
      q2_value = q2_ready ? value_q[q2_tag[IDX_W-1:0]] : 32'd0;
   end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer (default depth 16).
module tb_reorder_buffer;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        alloc_valid;
   logic [4:0]  alloc_rd;
   logic        alloc_ready;
   logic [31:0] alloc_tag;
   logic        wb_valid, wb_mispredict;
   logic [31:0] wb_tag, wb_value, wb_target;
   logic        commit_en, clear;
   logic [4:0]  commit_rd;
   logic [31:0] commit_value, commit_tag, clear_pc;
`ifdef ROB_FWD_EN
   logic [31:0] q1_tag = 32'd0, q2_tag = 32'd0, q1_value, q2_value;
   logic        q1_ready, q2_ready;
`endif

   int n_cmp = 0;
   int n_err = 0;

   reorder_buffer #(.ROB_DEPTH(16)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
      .wb_mispredict(wb_mispredict), .wb_target(wb_target),
      .commit_en(commit_en), .commit_rd(commit_rd),
      .commit_value(commit_value), .commit_tag(commit_tag),
      .clear(clear), .clear_pc(clear_pc)
`ifdef ROB_FWD_EN
      , .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready),
      .q2_ready(q2_ready), .q1_value(q1_value), .q2_value(q2_value)
`endif
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_valid   = 1'b0;
      alloc_rd      = 5'd0;
      wb_valid      = 1'b0;
      wb_tag        = 32'd0;
      wb_value      = 32'd0;
      wb_mispredict = 1'b0;
      wb_target     = 32'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rdy_in = 1'b1;
      rst_in = 1'b0;
      tick();
      tick();
      rst_in = 1'b1;
   endtask

   task automatic alloc(input logic [4:0] rd);
      alloc_valid = 1'b1;
      alloc_rd    = rd;
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic wb(input logic [31:0] tag, input logic [31:0] val,
                     input logic misp, input logic [31:0] tgt);
      wb_valid      = 1'b1;
      wb_tag        = tag;
      wb_value      = val;
      wb_mispredict = misp;
      wb_target     = tgt;
      tick();
      wb_valid      = 1'b0;
      wb_mispredict = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rdy_in = 1'b0;
      rst_in = 1'b0;

      // Reset state
      do_reset();
      check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
      check("rst_alloc_tag", alloc_tag, 32'd0);
      check("rst_commit_en", 32'(commit_en), 32'd0);
      check("rst_clear", 32'(clear), 32'd0);
      check("rst_commit_tag", commit_tag, 32'd0);
      check("rst_clear_pc", clear_pc, 32'd0);

      // Out-of-order writeback, in-order commit
      alloc(5'd5);
      alloc(5'd6);
      wb(32'd1, 32'h22, 1'b0, 32'd0);
      wb(32'd0, 32'h11, 1'b0, 32'd0);
      check("ooo_no_early_commit", 32'(commit_en), 32'd0);
      tick();
      check("ooo_c0_en", 32'(commit_en), 32'd1);
      check("ooo_c0_rd", 32'(commit_rd), 32'd5);
      check("ooo_c0_val", commit_value, 32'h11);
      check("ooo_c0_tag", commit_tag, 32'd0);
      tick();
      check("ooo_c1_en", 32'(commit_en), 32'd1);
      check("ooo_c1_rd", 32'(commit_rd), 32'd6);
      check("ooo_c1_val", commit_value, 32'h22);
      check("ooo_c1_tag", commit_tag, 32'd1);
      tick();
      check("ooo_idle_en", 32'(commit_en), 32'd0);
      check("ooo_tail", alloc_tag, 32'd2);

      // Full buffer, wrap, and no allocation while full even on retire
      do_reset();
      for (int i = 0; i < 16; i++) alloc(5'(i + 1));
      check("full_ready", 32'(alloc_ready), 32'd0);
      check("full_tag_wrap", alloc_tag, 32'd0);
      alloc(5'd30);
      check("full_rejected_tag", alloc_tag, 32'd0);
      wb(32'd0, 32'hAA, 1'b0, 32'd0);
      check("full_still_full", 32'(alloc_ready), 32'd0);
      alloc_valid = 1'b1;
      alloc_rd    = 5'd9;
      tick();
      alloc_valid = 1'b0;
      check("full_commit_en", 32'(commit_en), 32'd1);
      check("full_commit_rd", 32'(commit_rd), 32'd1);
      check("full_commit_val", commit_value, 32'hAA);
      check("full_commit_tag", commit_tag, 32'd0);
      check("full_ready_after", 32'(alloc_ready), 32'd1);
      check("full_tag_after", alloc_tag, 32'd0);

      // Mispredict flush with a same-cycle alloc and writeback discarded
      do_reset();
      alloc(5'd1);
      alloc(5'd2);
      alloc(5'd3);
      wb(32'd0, 32'h55, 1'b1, 32'h1000);
      check("flush_no_early", 32'(clear), 32'd0);
      alloc_valid = 1'b1;
      alloc_rd    = 5'd4;
      wb_valid    = 1'b1;
      wb_tag      = 32'd1;
      wb_value    = 32'h66;
      tick();
      idle_inputs();
      check("flush_commit_en", 32'(commit_en), 32'd1);
      check("flush_commit_val", commit_value, 32'h55);
      check("flush_clear", 32'(clear), 32'd1);
      check("flush_clear_pc", clear_pc, 32'h1000);
      check("flush_tail", alloc_tag, 32'd0);
      check("flush_ready", 32'(alloc_ready), 32'd1);
      tick();
      check("flush_clear_pulse", 32'(clear), 32'd0);
      check("flush_empty_no_commit", 32'(commit_en), 32'd0);
      check("flush_tail_held", alloc_tag, 32'd0);

      // rd=0 retires silently; out-of-range writeback ignored
      do_reset();
      alloc(5'd0);
      wb(32'd16, 32'h77, 1'b0, 32'd0);
      tick();
      check("oor_wb_no_commit", 32'(commit_en), 32'd0);
      check("oor_wb_tag_unchanged", commit_tag, 32'd0);
      wb(32'd0, 32'h99, 1'b0, 32'd0);
      tick();
      check("rd0_commit_en", 32'(commit_en), 32'd0);
      check("rd0_commit_val", commit_value, 32'h99);
      alloc(5'd3);
      wb(32'd1, 32'h33, 1'b0, 32'd0);
      tick();
      check("rd0_next_en", 32'(commit_en), 32'd1);
      check("rd0_next_tag", commit_tag, 32'd1);

      // rdy_in low freezes commit and allocation
      do_reset();
      alloc(5'd4);
      wb(32'd0, 32'h44, 1'b0, 32'd0);
      rdy_in      = 1'b0;
      alloc_valid = 1'b1;
      alloc_rd    = 5'd8;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("stall_no_commit_%0d", i), 32'(commit_en), 32'd0);
         check($sformatf("stall_tag_%0d", i), alloc_tag, 32'd1);
      end
      alloc_valid = 1'b0;
      rdy_in      = 1'b1;
      tick();
      check("stall_commit_en", 32'(commit_en), 32'd1);
      check("stall_commit_rd", 32'(commit_rd), 32'd4);
      check("stall_commit_val", commit_value, 32'h44);

      // Reset mid-operation discards a pending commit and flush
      alloc(5'd8);
      wb(32'd1, 32'h88, 1'b1, 32'h2000);
      rst_in = 1'b0;
      tick();
      check("midrst_commit_en", 32'(commit_en), 32'd0);
      check("midrst_clear", 32'(clear), 32'd0);
      rst_in = 1'b1;
      tick();
      check("midrst_after_commit", 32'(commit_en), 32'd0);
      check("midrst_tag", alloc_tag, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 16, number of entries; power of two, 2..32.
REQ-002 SHALL have clk_in, input, 1, sole clock; all state updates on posedge.
REQ-003 SHALL have rst_in, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have rdy_in, input, 1, global enable; low freezes all state.
REQ-005 SHALL have alloc_valid, input, 1, issue requests an entry this cycle.
REQ-006 SHALL have alloc_rd, input, 5, destination register of the issued instruction.
REQ-007 SHALL have alloc_ready, output, 1, entry available (combinational, not full).
REQ-008 SHALL have alloc_tag, output, 32, tag of the entry the next allocation gets (tail index, zero-extended).
REQ-009 SHALL have wb_valid / wb_tag[32] / wb_value[32] / wb_mispredict[1] / wb_target[32], inputs, execution result broadcast.
REQ-010 SHALL have commit_en, output, 1, regfile write strobe; drives the register file's commit Status_Change input.
REQ-011 SHALL have commit_rd[5] / commit_value[32] / commit_tag[32], outputs, regfile address, data and Number.
REQ-012 SHALL have clear, output, 1, flush pulse to issue, RS and regfile; clear_pc, output, 32, redirect PC.

Function
REQ-013 SHALL hold a circular buffer of ROB_DEPTH entries (busy, done, rd, value, mispredict, target) plus head, tail and a count of width log2(ROB_DEPTH)+1.
REQ-014 SHALL accept an allocation when alloc_valid & alloc_ready & rdy_in: entry[tail] busy=1, done=0, rd=alloc_rd; tail wraps from ROB_DEPTH-1 to 0.
REQ-015 SHALL drive alloc_ready low when count==ROB_DEPTH, even if a commit occurs in the same cycle.
REQ-016 SHALL, on wb_valid with wb_tag<ROB_DEPTH and entry busy, set done=1 and latch value, mispredict and target; it SHALL ignore any other wb_valid.
REQ-017 SHALL evaluate commit from registered state only; a writeback to the head entry commits no earlier than the next cycle.
REQ-018 SHALL retire at most one entry per cycle when count>0 and entry[head] is done: busy=0, head wraps.
REQ-019 SHALL, on retire, register commit_en=(rd!=0), commit_rd, commit_value and commit_tag=head for exactly one cycle; commit_en SHALL otherwise be 0.
REQ-020 SHALL update count by +alloc-retire, so simultaneous alloc and retire leave it unchanged.
REQ-021 SHALL, when the retiring entry has mispredict=1, also register clear=1 and clear_pc=target for one cycle, and empty the buffer at that edge (head=tail=count=0, all busy=0).
REQ-022 SHALL give a flush priority over any allocation or writeback in the same cycle; those are discarded.
REQ-023 SHALL, while rdy_in=0, hold all entries and pointers and register commit_en=0 and clear=0.

Reset
REQ-024 SHALL, when rst_in=0 at posedge regardless of rdy_in, zero head, tail, count and all busy/done bits.
REQ-025 SHALL have these reset output values: commit_en=0, commit_rd=0, commit_value=0, commit_tag=0, clear=0, clear_pc=0; alloc_ready=1 and alloc_tag=0 after reset.
REQ-026 SHALL, on reset mid-operation, discard all in-flight entries without emitting a commit or clear.

Configuration
REQ-027 SHALL, with ROB_FWD_EN defined, add inputs q1_tag/q2_tag[32] and outputs q1_ready/q2_ready[1] and q1_value/q2_value[32]; each qN_ready=1 iff the entry is busy and done, qN_value=entry value, else 0, combinationally.
REQ-028 SHALL, without ROB_FWD_EN, omit these ports and have identical remaining behaviour.

Verification
REQ-029 SHALL include a test that drives reset low for 2 cycles then high, and checks alloc_ready=1, alloc_tag=0, commit_en=0 and clear=0.
REQ-030 SHALL include a test that allocates rd=5 and rd=6 (tags 0,1), writes back tag1=0x22 and then tag0=0x11, and checks commit rd5=0x11 tag0 followed by rd6=0x22 tag1 on consecutive cycles.
REQ-031 SHALL include a test that performs 16 allocations without writeback, checks alloc_ready=0, then writes back tag0, and checks one commit, alloc_ready=1 and alloc_tag=0 (wrap).
REQ-032 SHALL include a test that allocates 3 entries, writes back tag0 with mispredict=1 and target=0x1000, and checks commit, clear=1, clear_pc=0x1000, count 0 and alloc_tag=0 on the next cycle.
REQ-033 SHALL include a test that allocates rd=0 and writes back, and checks that the entry retires with commit_en=0.
REQ-034 SHALL include a test that holds rdy_in=0 with a done head, checks that no commit occurs for 3 cycles, then raises rdy_in and checks the commit.
